// File: rtl/instr_exec_sequencer_if.sv
// Bundle of the sequencer's control, instruction-register and result signals.
//
// start/first_addr/count  : run request, sampled only while the sequencer is idle
// read_pointer            : address presented to the instruction register
// instruction_word        : {opc[3:0], op_a[31:0], op_b[31:0], low bits of rezultat}
// res_valid/res_ready     : result handshake
// res_addr/res_opc/result : location, opcode and 64-bit signed result
// busy/done               : run in progress / one-cycle end-of-run pulse
//
// slave  : the sequencer's view
// master : the environment's view (controller, instruction register, consumer)
interface instr_exec_sequencer_if;
    logic        start;
    logic [4:0]  first_addr;
    logic [5:0]  count;
    logic [4:0]  read_pointer;
    logic [72:0] instruction_word;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_addr;
    logic [3:0]  res_opc;
    logic [63:0] result;
    logic        busy;
    logic        done;

    modport slave (
        input  start, first_addr, count, instruction_word, res_ready,
        output read_pointer, res_valid, res_addr, res_opc, result, busy, done
    );

    modport master (
        output start, first_addr, count, instruction_word, res_ready,
        input  read_pointer, res_valid, res_addr, res_opc, result, busy, done
    );
endinterface

// File: rtl/instr_exec_sequencer.sv
// Instruction execution sequencer.
//
// Walks `count` consecutive instruction-register locations starting at `first_addr`,
// evaluates each opcode on its two signed 32-bit operands and hands out one 64-bit
// signed result per location over a valid/ready handshake. DIV/MOD with a nonzero
// divisor use an iterative restoring divider (DIV_CYCLES iterations plus one cycle
// to apply signs); every other opcode takes a single EXEC cycle.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_exec_sequencer_if.slave (see interface file)
module instr_exec_sequencer #(
    parameter int unsigned NUM_LOC    = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic                   clk,
    input logic                   reset_n,
    instr_exec_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    localparam logic [3:0] OpcZero  = 4'd0;
    localparam logic [3:0] OpcPassA = 4'd1;
    localparam logic [3:0] OpcPassB = 4'd2;
    localparam logic [3:0] OpcAdd   = 4'd3;
    localparam logic [3:0] OpcSub   = 4'd4;
    localparam logic [3:0] OpcMult  = 4'd5;
    localparam logic [3:0] OpcDiv   = 4'd6;
    localparam logic [3:0] OpcMod   = 4'd7;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StDivide, StOut} state_e;

    state_e          state_q, state_d;
    logic [4:0]      rptr_q, rptr_d;
    logic [5:0]      remaining_q, remaining_d;
    logic [3:0]      opc_q, opc_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [4:0]      res_addr_q, res_addr_d;
    logic [63:0]     result_q, result_d;
    logic            done_q, done_d;
    // Partial remainder, and a register that shifts the dividend out MSB-first while
    // the quotient bits shift in from the bottom.
    logic [31:0]     div_rem_q, div_rem_d;
    logic [31:0]     div_quo_q, div_quo_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    // Word layout: the 73-bit word only carries the low 5 bits of the stored
    // result field, which this block ignores.
    logic [3:0]  iw_opc;
    logic [31:0] iw_a;
    logic [31:0] iw_b;
    logic        unused_iw_rez;

    assign iw_opc        = bus.instruction_word[72:69];
    assign iw_a          = bus.instruction_word[68:37];
    assign iw_b          = bus.instruction_word[36:5];
    assign unused_iw_rez = ^bus.instruction_word[4:0];

    function automatic logic [31:0] abs32(input logic [31:0] v);
        // -2^31 maps to 32'h8000_0000, which is correct as an unsigned magnitude.
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic signed [63:0] sa, sb;
    logic [63:0]        exec_res;

    assign sa = {{32{op_a_q[31]}}, op_a_q};
    assign sb = {{32{op_b_q[31]}}, op_b_q};

    always_comb begin
        exec_res = '0;
        case (opc_q)
            OpcZero:  exec_res = '0;
            OpcPassA: exec_res = sa;
            OpcPassB: exec_res = sb;
            OpcAdd:   exec_res = sa + sb;
            OpcSub:   exec_res = sa - sb;
            OpcMult:  exec_res = sa * sb;
            // Only a zero divisor reaches EXEC for DIV/MOD.
            OpcDiv:   exec_res = '0;
            OpcMod:   exec_res = '0;
            default:  exec_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divider step on magnitudes
    // ------------------------------------------------------------------
    logic [31:0] div_divisor;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_sub;
    logic [63:0] quo64, rem64, div_res;

    assign div_divisor = abs32(op_b_q);
    assign div_shift   = {div_rem_q, div_quo_q[31]};
    assign div_fits    = div_shift >= {1'b0, div_divisor};
    // When the trial fits the difference is below the divisor, so 32 bits suffice.
    assign div_sub     = div_shift[31:0] - div_divisor;

    assign quo64 = {32'd0, div_quo_q};
    assign rem64 = {32'd0, div_rem_q};

    always_comb begin
        div_res = '0;
        if (opc_q == OpcDiv) begin
            // Done in 64 bits so that -2^31 / -1 yields +2^31 exactly.
            div_res = (op_a_q[31] ^ op_b_q[31]) ? -quo64 : quo64;
        end else begin
            div_res = op_a_q[31] ? -rem64 : rem64;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [4:0] rptr_next;
    assign rptr_next = (rptr_q == 5'(NUM_LOC - 1)) ? 5'd0 : rptr_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        rptr_d      = rptr_q;
        remaining_d = remaining_q;
        opc_d       = opc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_addr_d  = res_addr_q;
        result_d    = result_q;
        done_d      = 1'b0;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_cnt_d   = div_cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rptr_d      = bus.first_addr;
                    remaining_d = bus.count;
                    if (bus.count == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end

            StFetch: begin
                opc_d      = iw_opc;
                op_a_d     = iw_a;
                op_b_d     = iw_b;
                res_addr_d = rptr_q;
                div_rem_d  = '0;
                div_quo_d  = abs32(iw_a);
                div_cnt_d  = '0;
                if ((iw_opc == OpcDiv || iw_opc == OpcMod) && iw_b != 32'd0) begin
                    state_d = StDivide;
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                result_d = exec_res;
                state_d  = StOut;
            end

            StDivide: begin
                if (div_cnt_q == CntW'(DIV_CYCLES)) begin
                    // Extra cycle after the last iteration applies the signs.
                    result_d = div_res;
                    state_d  = StOut;
                end else begin
                    div_rem_d = div_fits ? div_sub : div_shift[31:0];
                    div_quo_d = {div_quo_q[30:0], div_fits};
                    div_cnt_d = div_cnt_q + CntW'(1);
                end
            end

            StOut: begin
                if (bus.res_ready) begin
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        rptr_d  = rptr_next;
                        state_d = StFetch;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rptr_q      <= '0;
            remaining_q <= '0;
            opc_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_addr_q  <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            remaining_q <= remaining_d;
            opc_q       <= opc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_addr_q  <= res_addr_d;
            result_q    <= result_d;
            done_q      <= done_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    // res_valid and busy decode straight from the state so reset clears them at once.
    assign bus.read_pointer = rptr_q;
    assign bus.res_valid    = (state_q == StOut);
    assign bus.res_addr     = res_addr_q;
    assign bus.res_opc      = opc_q;
    assign bus.result       = result_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
module tb_instr_exec_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_exec_sequencer_if bus ();

    // Instruction register model, read combinationally.
    logic [72:0] mem     [32];
    logic [63:0] exp_arr [32];

    assign bus.instruction_word = mem[bus.read_pointer];

    instr_exec_sequencer #(
        .NUM_LOC   (32),
        .DIV_CYCLES(32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  loc;
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic logic [63:0] model(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (opc)
            4'd1:    return 64'(sa);
            4'd2:    return 64'(sb);
            4'd3:    return 64'(sa + sb);
            4'd4:    return 64'(sa - sb);
            4'd5:    return 64'(sa * sb);
            4'd6:    return (sb == 0) ? 64'd0 : 64'(sa / sb);
            4'd7:    return (sb == 0) ? 64'd0 : 64'(sa % sb);
            default: return 64'd0;
        endcase
    endfunction

    function automatic int latency_of(input logic [72:0] w);
        return ((w[72:69] == 4'd6 || w[72:69] == 4'd7) && w[36:5] != 32'd0) ? 34 : 2;
    endfunction

    function automatic logic [72:0] mkword(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] junk);
        return {opc, a, b, junk};
    endfunction

    task automatic load(input logic [4:0] loc, input logic [3:0] opc, input logic [31:0] a,
                        input logic [31:0] b);
        mem[loc]     = mkword(opc, a, b, 5'd0);
        exp_arr[loc] = model(opc, a, b);
    endtask

    // Called at 1 time unit after an edge; returns 1 time unit after start edge E.
    task automatic start_run(input logic [4:0] fa, input logic [5:0] cnt);
        bus.first_addr = fa;
        bus.count      = cnt;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Collect n results; stall = cycles res_ready is held low once valid is seen;
    // k0 = edges already elapsed since the start edge.
    task automatic collect(input logic [4:0] fa, input int n, input int stall, input int k0,
                           input string tag);
        int          k;
        logic [4:0]  loc;
        logic [72:0] w;
        k = k0;
        for (int i = 0; i < n; i++) begin
            loc = 5'((int'(fa) + i) % 32);
            w   = mem[loc];
            while (!bus.res_valid && k < 60) begin
                @(posedge clk); #1;
                k++;
            end
            if (!bus.res_valid) begin
                check({tag, " valid_timeout"}, 64'(bus.res_valid), 64'd1);
                return;
            end
            check({tag, " latency"}, 64'(k), 64'(latency_of(w)));
            check({tag, " result"}, bus.result, exp_arr[loc]);
            check({tag, " res_addr"}, 64'(bus.res_addr), 64'(loc));
            check({tag, " res_opc"}, 64'(bus.res_opc), 64'(w[72:69]));
            check({tag, " read_pointer"}, 64'(bus.read_pointer), 64'(loc));
            check({tag, " busy"}, 64'(bus.busy), 64'd1);
            check({tag, " done_early"}, 64'(bus.done), 64'd0);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check({tag, " stall valid"}, 64'(bus.res_valid), 64'd1);
                check({tag, " stall result"}, bus.result, exp_arr[loc]);
                check({tag, " stall res_addr"}, 64'(bus.res_addr), 64'(loc));
                check({tag, " stall read_pointer"}, 64'(bus.read_pointer), 64'(loc));
                check({tag, " stall done"}, 64'(bus.done), 64'd0);
            end
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
            k = 0;
            if (i == n - 1) begin
                check({tag, " done"}, 64'(bus.done), 64'd1);
                check({tag, " idle valid"}, 64'(bus.res_valid), 64'd0);
                check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
            end else begin
                check({tag, " done_mid"}, 64'(bus.done), 64'd0);
            end
        end
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3: begin
                v = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.count      = '0;
        bus.res_ready  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = '0;
            exp_arr[i] = '0;
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset read_pointer", 64'(bus.read_pointer), 64'd0);
        check("reset res_valid", 64'(bus.res_valid), 64'd0);
        check("reset res_addr", 64'(bus.res_addr), 64'd0);
        check("reset res_opc", 64'(bus.res_opc), 64'd0);
        check("reset result", bus.result, 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table.
        tbl[0]  = '{5'd0,  4'd3, 32'd5,         32'd3,          64'd8};
        tbl[1]  = '{5'd1,  4'd4, -32'sd7,       32'd4,          -64'sd11};
        tbl[2]  = '{5'd2,  4'd5, -32'sd15,      32'd15,         -64'sd225};
        tbl[3]  = '{5'd5,  4'd6, -32'sd15,      32'd4,          -64'sd3};
        tbl[4]  = '{5'd6,  4'd7, -32'sd15,      32'd4,          -64'sd3};
        tbl[5]  = '{5'd7,  4'd6, 32'd9,         32'd0,          64'd0};
        tbl[6]  = '{5'd10, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000};
        tbl[7]  = '{5'd11, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF,  64'd0};
        tbl[8]  = '{5'd12, 4'd9, 32'd1,         32'd2,          64'd0};
        tbl[9]  = '{5'd13, 4'd2, 32'd100,       32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF};
        tbl[10] = '{5'd14, 4'd0, 32'd7,         32'd7,          64'd0};
        tbl[11] = '{5'd15, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        tbl[12] = '{5'd16, 4'd6, 32'd7,         -32'sd2,        -64'sd3};
        tbl[13] = '{5'd17, 4'd7, 32'd7,         -32'sd2,        64'd1};
        for (int i = 0; i < 14; i++) begin
            mem[tbl[i].loc]     = mkword(tbl[i].opc, tbl[i].a, tbl[i].b, 5'd0);
            exp_arr[tbl[i].loc] = tbl[i].exp;
        end
        start_run(5'd0, 6'd3);
        collect(5'd0, 3, 0, 0, "t1");
        start_run(5'd5, 6'd3);
        collect(5'd5, 3, 0, 0, "t2");
        start_run(5'd10, 6'd8);
        collect(5'd10, 8, 0, 0, "tbl");

        // Wrap-around.
        for (int i = 30; i < 34; i++) load(5'(i % 32), 4'd1, 32'(i % 32), 32'd77);
        start_run(5'd30, 6'd4);
        collect(5'd30, 4, 0, 0, "wrap");

        // Backpressure.
        load(5'd20, 4'd3, 32'd1000, -32'sd1);
        load(5'd21, 4'd4, 32'd1, 32'd2);
        start_run(5'd20, 6'd2);
        collect(5'd20, 2, 10, 0, "bp");

        // start while busy is ignored.
        load(5'd22, 4'd1, 32'd22, 32'd0);
        load(5'd23, 4'd2, 32'd0, 32'd23);
        start_run(5'd22, 6'd2);
        bus.first_addr = 5'd3;
        bus.count      = 6'd1;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        collect(5'd22, 2, 0, 1, "busy_start");

        // count = 0.
        start_run(5'd9, 6'd0);
        check("cnt0 done", 64'(bus.done), 64'd1);
        check("cnt0 valid", 64'(bus.res_valid), 64'd0);
        check("cnt0 busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check("cnt0 done_one_cycle", 64'(bus.done), 64'd0);
        check("cnt0 valid_after", 64'(bus.res_valid), 64'd0);

        // Asynchronous reset in the middle of a divide.
        load(5'd24, 4'd6, 32'd1000, 32'd7);
        start_run(5'd24, 6'd1);
        repeat (10) @(posedge clk);
        #1;
        check("divide busy", 64'(bus.busy), 64'd1);
        check("divide read_pointer", 64'(bus.read_pointer), 64'd24);
        #2;
        reset_n = 1'b0;
        #1;
        check("async read_pointer", 64'(bus.read_pointer), 64'd0);
        check("async res_valid", 64'(bus.res_valid), 64'd0);
        check("async res_addr", 64'(bus.res_addr), 64'd0);
        check("async res_opc", 64'(bus.res_opc), 64'd0);
        check("async result", bus.result, 64'd0);
        check("async busy", 64'(bus.busy), 64'd0);
        check("async done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset done", 64'(bus.done), 64'd0);
        start_run(5'd24, 6'd1);
        collect(5'd24, 1, 0, 0, "after_reset");

        // Randomized runs against the reference model.
        for (int r = 0; r < 20; r++) begin
            logic [4:0] fa;
            int         n;
            int         st;
            for (int i = 0; i < 32; i++) begin
                logic [3:0]  opc;
                logic [31:0] a, b;
                opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 7));
                a = rand_op();
                b = rand_op();
                mem[i]     = mkword(opc, a, b, 5'($urandom));
                exp_arr[i] = model(opc, a, b);
            end
            fa = 5'($urandom_range(0, 31));
            n  = $urandom_range(1, 8);
            st = $urandom_range(0, 2);
            start_run(fa, 6'(n));
            collect(fa, n, st, 0, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
